// File: rtl/instr_fetch_mem.sv
// Instruction memory with request/response fetch port, fixed read latency, program-load port
// and fetch flush. Reset reloads the boot image; fetch and load are serialised by one FSM.
module instr_fetch_mem #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_idle;
    logic              w_ld_fire;
    logic              w_req_fire;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_err;
    logic [DATA_W-1:0] w_rd_data;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < DEPTH;
    endfunction

    function automatic logic [DATA_W-1:0] boot_word(input int idx);
        case (idx)
            0:       return DATA_W'(8'h1B);
            1:       return DATA_W'(8'h73);
            2:       return DATA_W'(8'h4E);
            3:       return DATA_W'(8'hC5);
            4:       return DATA_W'(8'h0C);
            5:       return DATA_W'(8'h59);
            default: return '0;
        endcase
    endfunction

    assign w_idle     = (r_state == S_IDLE);
    assign ld_ready   = w_idle;
    assign req_ready  = w_idle & ~ld_en & ~flush;
    assign w_ld_fire  = ld_en & w_idle & in_range(ld_addr);
    assign w_req_fire = req_valid & req_ready;

    // With LATENCY==1 the word is captured on the accept edge, so read straight from req_addr.
    assign w_rd_addr  = w_idle ? req_addr : r_addr_q;
    assign w_rd_err   = ~in_range(w_rd_addr);
    assign w_rd_data  = w_rd_err ? '0 : r_mem[w_rd_addr[IDX_W-1:0]];

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

    // NOTE: the array is reset to the boot image, so it maps to flops, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= boot_word(i);
            end
        end else if (w_ld_fire) begin
            r_mem[ld_addr[IDX_W-1:0]] <= ld_data;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr_q     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_addr_q <= req_addr;
                        if (LATENCY == 1) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= w_rd_data;
                            r_resp_err   <= w_rd_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 3'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 3'd1) begin
                        r_state      <= S_RESP;
                        r_cnt        <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_rd_data;
                        r_resp_err   <= w_rd_err;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    // Data/err keep their last value after leaving RESP.
                    if (flush || resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: three instances (LATENCY 1, LATENCY 3 with DEPTH 16,
// LATENCY 4) exercised with hand-computed expectations.
`timescale 1ns/1ps
module tb_instr_fetch_mem;

    localparam int N = 3;
    localparam int LAT [N] = '{1, 3, 4};

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid  [N];
    logic [7:0] req_addr   [N];
    logic       req_ready  [N];
    logic       resp_valid [N];
    logic       resp_ready [N];
    logic [7:0] resp_data  [N];
    logic       resp_err   [N];
    logic       flush      [N];
    logic       ld_en      [N];
    logic [7:0] ld_addr    [N];
    logic [7:0] ld_data    [N];
    logic       ld_ready   [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_err(resp_err[0]), .flush(flush[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .ld_ready(ld_ready[0])
    );

    instr_fetch_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_err(resp_err[1]), .flush(flush[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .ld_ready(ld_ready[1])
    );

    instr_fetch_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_addr(req_addr[2]), .req_ready(req_ready[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_data(resp_data[2]), .resp_err(resp_err[2]), .flush(flush[2]),
        .ld_en(ld_en[2]), .ld_addr(ld_addr[2]), .ld_data(ld_data[2]), .ld_ready(ld_ready[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Present one request and let it be accepted on the next rising edge.
    task automatic issue(input int d, input logic [7:0] addr);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        #1;
        check($sformatf("req_ready_accept[%0d]", d), 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask

    // Ends at the negedge of the first cycle with resp_valid expected high.
    task automatic await_resp(input int d, input logic [7:0] exp_data, input logic exp_err);
        for (int k = 1; k < LAT[d]; k++) begin
            @(negedge clk);
            check($sformatf("lat_quiet[%0d]", d), 32'(resp_valid[d]), 32'd0);
        end
        @(negedge clk);
        check($sformatf("resp_valid[%0d]", d), 32'(resp_valid[d]), 32'd1);
        check($sformatf("resp_data[%0d]", d), 32'(resp_data[d]), 32'(exp_data));
        check($sformatf("resp_err[%0d]", d), 32'(resp_err[d]), 32'(exp_err));
    endtask

    task automatic consume(input int d);
        logic saved;
        saved         = resp_ready[d];
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1 resp_ready[d] = saved;
        @(negedge clk);
        check($sformatf("consumed_valid[%0d]", d), 32'(resp_valid[d]), 32'd0);
        check($sformatf("idle_req_ready[%0d]", d), 32'(req_ready[d]), 32'd1);
    endtask

    task automatic fetch(input int d, input logic [7:0] addr, input logic [7:0] exp_data,
                         input logic exp_err);
        issue(d, addr);
        await_resp(d, exp_data, exp_err);
        consume(d);
    endtask

    task automatic load(input int d, input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        ld_en[d]   = 1'b1;
        ld_addr[d] = addr;
        ld_data[d] = data;
        #1;
        check($sformatf("ld_ready[%0d]", d), 32'(ld_ready[d]), 32'd1);
        @(posedge clk);
        #1 ld_en[d] = 1'b0;
    endtask

    initial begin
        logic [7:0] boot [6];
        boot = '{8'h1B, 8'h73, 8'h4E, 8'hC5, 8'h0C, 8'h59};

        rst = 1'b1;
        for (int d = 0; d < N; d++) begin
            req_valid[d]  = 1'b0;
            req_addr[d]   = '0;
            resp_ready[d] = 1'b0;
            flush[d]      = 1'b0;
            ld_en[d]      = 1'b0;
            ld_addr[d]    = '0;
            ld_data[d]    = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check($sformatf("rst_valid[%0d]", d), 32'(resp_valid[d]), 32'd0);
            check($sformatf("rst_data[%0d]", d), 32'(resp_data[d]), 32'd0);
            check($sformatf("rst_err[%0d]", d), 32'(resp_err[d]), 32'd0);
            check($sformatf("rst_req_ready[%0d]", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("rst_ld_ready[%0d]", d), 32'(ld_ready[d]), 32'd1);
        end

        // Boot image through the single-cycle instance with resp_ready held high.
        resp_ready[0] = 1'b1;
        for (int a = 0; a < 6; a++) begin
            fetch(0, 8'(a), boot[a], 1'b0);
        end
        resp_ready[0] = 1'b0;

        // LATENCY 3, response held under back-pressure while another request waits.
        issue(1, 8'd3);
        await_resp(1, 8'hC5, 1'b0);
        req_valid[1] = 1'b1;
        req_addr[1]  = 8'd5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid[1]), 32'd1);
            check("hold_data", 32'(resp_data[1]), 32'hC5);
            check("hold_req_ready", 32'(req_ready[1]), 32'd0);
        end
        req_valid[1] = 1'b0;
        consume(1);

        // Load wins over a same-cycle fetch.
        @(negedge clk);
        ld_en[0]     = 1'b1;
        ld_addr[0]   = 8'd10;
        ld_data[0]   = 8'hA5;
        req_valid[0] = 1'b1;
        req_addr[0]  = 8'd0;
        #1;
        check("ld_vs_req_ld_ready", 32'(ld_ready[0]), 32'd1);
        check("ld_vs_req_req_ready", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        ld_en[0]     = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("ld_vs_req_no_resp", 32'(resp_valid[0]), 32'd0);
        fetch(0, 8'd10, 8'hA5, 1'b0);

        // Flush in IDLE blocks the request but not the load.
        @(negedge clk);
        flush[0]     = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 8'd1;
        ld_en[0]     = 1'b1;
        ld_addr[0]   = 8'd11;
        ld_data[0]   = 8'h3C;
        #1;
        check("idle_flush_req_ready", 32'(req_ready[0]), 32'd0);
        check("idle_flush_ld_ready", 32'(ld_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        flush[0]     = 1'b0;
        req_valid[0] = 1'b0;
        ld_en[0]     = 1'b0;
        @(negedge clk);
        check("idle_flush_no_resp", 32'(resp_valid[0]), 32'd0);
        fetch(0, 8'd11, 8'h3C, 1'b0);

        // Flush in RESP drops valid but leaves data in place.
        issue(0, 8'd2);
        await_resp(0, 8'h4E, 1'b0);
        flush[0] = 1'b1;
        @(posedge clk);
        #1 flush[0] = 1'b0;
        @(negedge clk);
        check("resp_flush_valid", 32'(resp_valid[0]), 32'd0);
        check("resp_flush_data_kept", 32'(resp_data[0]), 32'h4E);
        check("resp_flush_req_ready", 32'(req_ready[0]), 32'd1);

        // DEPTH 16 boundaries: 15 in range, 16 and 20 out of range; 20 must not alias to 4.
        fetch(1, 8'd20, 8'h00, 1'b1);
        fetch(1, 8'd15, 8'h00, 1'b0);
        fetch(1, 8'd16, 8'h00, 1'b1);
        load(1, 8'd20, 8'h77);
        @(negedge clk);
        check("oor_load_no_hang", 32'(ld_ready[1]), 32'd1);
        fetch(1, 8'd4, 8'h0C, 1'b0);
        fetch(1, 8'd20, 8'h00, 1'b1);
        load(1, 8'd15, 8'hE1);
        fetch(1, 8'd15, 8'hE1, 1'b0);

        // LATENCY 4, flush while waiting: no response may ever appear.
        issue(2, 8'd1);
        @(negedge clk);
        flush[2] = 1'b1;
        #1;
        check("wait_ld_ready", 32'(ld_ready[2]), 32'd0);
        @(posedge clk);
        #1 flush[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("wait_flush_quiet", 32'(resp_valid[2]), 32'd0);
        end
        check("wait_flush_req_ready", 32'(req_ready[2]), 32'd1);
        fetch(2, 8'd1, 8'h73, 1'b0);

        // Reset mid-flight: overwritten word and loaded words return to the boot image.
        load(2, 8'd2, 8'h00);
        fetch(2, 8'd2, 8'h00, 1'b0);
        issue(1, 8'd5);
        await_resp(1, 8'h59, 1'b0);
        issue(2, 8'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_valid_l3", 32'(resp_valid[1]), 32'd0);
        check("async_rst_data_l3", 32'(resp_data[1]), 32'd0);
        check("async_rst_valid_l4", 32'(resp_valid[2]), 32'd0);
        check("async_rst_ld_ready_l4", 32'(ld_ready[2]), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(resp_valid[2]), 32'd0);
        end
        fetch(2, 8'd2, 8'h4E, 1'b0);
        fetch(0, 8'd10, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
